// File: rtl/range_cnt_pkg.sv
// Shared types and helpers for the windowed up/down counter: run-time mode
// encoding, a window clamp and the parameter legality rule.
package range_cnt_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP   = 2'b00,
        MODE_SAT    = 2'b01,
        MODE_BOUNCE = 2'b10,
        MODE_RSVD   = 2'b11
    } range_mode_e;

    function automatic longint unsigned clamp_val(
        input longint unsigned v,
        input longint unsigned lo,
        input longint unsigned hi
    );
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    function automatic bit params_legal(
        input int     width,
        input longint min_v,
        input longint max_v,
        input longint step,
        input longint prescale
    );
        longint top;
        if (width < 1 || width > 31)
            return 1'b0;
        top = (longint'(1) << width) - 1;
        return (min_v >= 0) && (min_v < max_v) && (max_v <= top) &&
               (step >= 1) && (step <= max_v - min_v) && (prescale >= 1);
    endfunction

endpackage

// File: rtl/range_updown_counter_gen_if.sv
// Control/status bundle of the windowed counter; the counter is the slave,
// whoever drives en/load/mode is the master.
interface range_updown_counter_gen_if #(
    parameter int WIDTH = 6
);
    logic             en;
    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             u_d;
    logic [1:0]       mode;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             at_max;
    logic             at_min;
    logic             term;
    logic             load_clamped;

    modport master (
        output en, load, load_data, u_d, mode,
        input  count, dir, at_max, at_min, term, load_clamped
    );

    modport slave (
        input  en, load, load_data, u_d, mode,
        output count, dir, at_max, at_min, term, load_clamped
    );
endinterface

// File: rtl/range_cnt_prescaler.sv
// Enable divider: passes every PRESCALE-th en_in pulse to en_out.
// clr restarts the division so the next step is a full PRESCALE cycles away.
module range_cnt_prescaler #(
    parameter int PRESCALE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en_in,
    output logic en_out
);
    generate
        if (PRESCALE <= 1) begin : g_bypass
            logic w_unused;
            assign w_unused = ^{clk, rst, clr};
            assign en_out   = en_in;
        end else begin : g_div
            localparam int             CW   = $clog2(PRESCALE);
            localparam logic [CW-1:0]  LAST = CW'(PRESCALE - 1);
            logic [CW-1:0] r_div;

            always_ff @(posedge clk) begin
                if (rst || clr)
                    r_div <= '0;
                else if (en_in)
                    r_div <= (r_div == LAST) ? '0 : r_div + 1'b1;
            end

            assign en_out = en_in && (r_div == LAST);
        end
    endgenerate
endmodule

// File: rtl/range_updown_counter_gen.sv
// Windowed up/down counter with wrap, saturate and bounce modes, clamped load
// and boundary pulses. Optional enable divider under RANGE_CNT_PRESCALE_EN.
module range_updown_counter_gen
    import range_cnt_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int MIN_VAL  = 10,
    parameter int MAX_VAL  = 40,
    parameter int STEP     = 1,
    parameter int PRESCALE = 4
) (
    input logic                      clk,
    input logic                      rst,
    range_updown_counter_gen_if.slave cnt_if
);
    generate
        if (!params_legal(WIDTH, MIN_VAL, MAX_VAL, STEP, PRESCALE)) begin : g_illegal
            $error("range_updown_counter_gen: illegal WIDTH/MIN_VAL/MAX_VAL/STEP/PRESCALE");
        end
    endgenerate

    // Arithmetic is one bit wider than the count so a step past the top of
    // the window is visible instead of silently wrapping.
    localparam logic [WIDTH:0] MIN_X      = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X      = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_X     = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MIN_STEP_X = (WIDTH+1)'(MIN_VAL + STEP);

    logic [WIDTH-1:0] r_count;
    logic             r_dir;
    logic             r_term;
    logic             r_load_clamped;

    logic [WIDTH:0]    w_count_ext;
    logic [WIDTH:0]    w_up;
    logic [WIDTH:0]    w_dn;
    logic [WIDTH:0]    w_next_ext;
    logic              w_dir_next;
    logic              w_term_next;
    logic              w_clamped_next;
    logic              w_out_of_window;
    logic              w_step;
    longint unsigned   w_load_ext;
    longint unsigned   w_load_clamp;
    range_mode_e       w_mode;

    assign w_count_ext     = {1'b0, r_count};
    assign w_up            = w_count_ext + STEP_X;
    assign w_dn            = w_count_ext - STEP_X;
    assign w_out_of_window = (w_count_ext < MIN_X) || (w_count_ext > MAX_X);
    assign w_load_ext      = 64'(cnt_if.load_data);
    assign w_load_clamp    = clamp_val(w_load_ext, 64'(MIN_VAL), 64'(MAX_VAL));
    assign w_mode          = range_mode_e'(cnt_if.mode);

`ifdef RANGE_CNT_PRESCALE_EN
    range_cnt_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clr    (cnt_if.load),
        .en_in  (cnt_if.en & ~w_out_of_window),
        .en_out (w_step)
    );
`else
    assign w_step = cnt_if.en;
`endif

    always_comb begin
        w_next_ext     = w_count_ext;
        w_dir_next     = r_dir;
        w_term_next    = 1'b0;
        w_clamped_next = 1'b0;
        if (w_out_of_window) begin
            w_next_ext = MIN_X;
        end else if (cnt_if.load) begin
            w_next_ext     = (WIDTH+1)'(w_load_clamp);
            w_clamped_next = (w_load_clamp != w_load_ext);
            w_dir_next     = cnt_if.u_d;
        end else if (w_step) begin
            case (w_mode)
                MODE_SAT: begin
                    w_dir_next = cnt_if.u_d;
                    if (cnt_if.u_d) begin
                        if (w_up >= MAX_X) begin
                            w_next_ext  = MAX_X;
                            w_term_next = 1'b1;
                        end else begin
                            w_next_ext = w_up;
                        end
                    end else if (w_count_ext <= MIN_STEP_X) begin
                        w_next_ext  = MIN_X;
                        w_term_next = 1'b1;
                    end else begin
                        w_next_ext = w_dn;
                    end
                end
                MODE_BOUNCE: begin
                    // Reaching an edge reverses immediately, so the counter
                    // never dwells two cycles on a boundary.
                    if (r_dir) begin
                        if (w_up >= MAX_X) begin
                            w_next_ext  = MAX_X;
                            w_dir_next  = 1'b0;
                            w_term_next = 1'b1;
                        end else begin
                            w_next_ext = w_up;
                        end
                    end else if (w_count_ext <= MIN_STEP_X) begin
                        w_next_ext  = MIN_X;
                        w_dir_next  = 1'b1;
                        w_term_next = 1'b1;
                    end else begin
                        w_next_ext = w_dn;
                    end
                end
                default: begin
                    w_dir_next = cnt_if.u_d;
                    if (cnt_if.u_d) begin
                        if (w_up > MAX_X) begin
                            w_next_ext  = MIN_X + (w_up - MAX_X - 1'b1);
                            w_term_next = 1'b1;
                        end else begin
                            w_next_ext = w_up;
                        end
                    end else if (w_count_ext < MIN_STEP_X) begin
                        w_next_ext  = MAX_X + 1'b1 - (MIN_STEP_X - w_count_ext);
                        w_term_next = 1'b1;
                    end else begin
                        w_next_ext = w_dn;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count        <= MIN_X[WIDTH-1:0];
            r_dir          <= 1'b1;
            r_term         <= 1'b0;
            r_load_clamped <= 1'b0;
        end else begin
            r_count        <= w_next_ext[WIDTH-1:0];
            r_dir          <= w_dir_next;
            r_term         <= w_term_next;
            r_load_clamped <= w_clamped_next;
        end
    end

    assign cnt_if.count        = r_count;
    assign cnt_if.dir          = r_dir;
    assign cnt_if.term         = r_term;
    assign cnt_if.load_clamped = r_load_clamped;
    assign cnt_if.at_max       = (w_count_ext == MAX_X);
    assign cnt_if.at_min       = (w_count_ext == MIN_X);
endmodule
